// File: rtl/game_controller_if.sv
// Port bundle for game_controller: move/round requests in, board, tallies and status out.
// The win_cells mask exists only when GAME_CONTROLLER_WIN_LINE_EN is defined.
interface game_controller_if;
  logic [3:0]  cell_sel;
  logic        place;
  logic        new_round;
  logic [17:0] grid;
  logic [3:0]  p1_score;
  logic [3:0]  p2_score;
  logic [3:0]  tie_score;
  logic        turn;
  logic        round_over;
  logic [1:0]  winner;
  logic        move_err;
`ifdef GAME_CONTROLLER_WIN_LINE_EN
  logic [8:0]  win_cells;

  modport master (
    output cell_sel, place, new_round,
    input  grid, p1_score, p2_score, tie_score, turn, round_over, winner, move_err, win_cells
  );
  modport slave (
    input  cell_sel, place, new_round,
    output grid, p1_score, p2_score, tie_score, turn, round_over, winner, move_err, win_cells
  );
`else
  modport master (
    output cell_sel, place, new_round,
    input  grid, p1_score, p2_score, tie_score, turn, round_over, winner, move_err
  );
  modport slave (
    input  cell_sel, place, new_round,
    output grid, p1_score, p2_score, tie_score, turn, round_over, winner, move_err
  );
`endif
endinterface

// File: rtl/game_controller.sv
// Tic-tac-toe round controller: PLAY/CHECK/OVER FSM with wrapping score tallies.
// Optional win_cells mask output enabled by GAME_CONTROLLER_WIN_LINE_EN.
module game_controller #(
  parameter logic [3:0] SCORE_MAX = 4'd9
) (
  input logic        clk,
  input logic        reset,
  game_controller_if.slave bus
);

  typedef enum logic [1:0] {StPlay, StCheck, StOver} state_e;

  // One 9-bit cell mask per line: rows, columns, diagonals.
  localparam logic [71:0] LINE_MASKS = {
    9'b000000111, 9'b000111000, 9'b111000000,
    9'b001001001, 9'b010010010, 9'b100100100,
    9'b100010001, 9'b001010100
  };

  state_e      r_state;
  logic [17:0] r_grid;
  logic [3:0]  r_p1_score;
  logic [3:0]  r_p2_score;
  logic [3:0]  r_tie_score;
  logic        r_turn;
  logic        r_start;
  logic [1:0]  r_winner;
  logic        r_move_err;
  logic [8:0]  r_win_cells;

  logic [1:0]  w_code;
  logic [8:0]  w_mine;
  logic [8:0]  w_full;
  logic [8:0]  w_win_mask;
  logic        w_sel_free;

  function automatic logic [3:0] bump(input logic [3:0] v);
    return (v == SCORE_MAX) ? 4'd0 : v + 4'd1;
  endfunction

  // Only the player who just moved can have completed a line.
  always_comb begin
    w_code     = r_turn ? 2'b10 : 2'b01;
    w_mine     = '0;
    w_full     = '0;
    w_win_mask = '0;
    w_sel_free = 1'b0;
    for (int k = 0; k < 9; k++) begin
      w_mine[k] = (r_grid[17-2*k -: 2] == w_code);
      w_full[k] = (r_grid[17-2*k -: 2] != 2'b00);
      if (bus.cell_sel == 4'(k)) w_sel_free = ~w_full[k];
    end
    for (int i = 0; i < 8; i++) begin
      if ((w_mine & LINE_MASKS[9*i +: 9]) == LINE_MASKS[9*i +: 9]) begin
        w_win_mask = w_win_mask | LINE_MASKS[9*i +: 9];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StPlay;
      r_grid      <= '0;
      r_p1_score  <= '0;
      r_p2_score  <= '0;
      r_tie_score <= '0;
      r_turn      <= 1'b0;
      r_start     <= 1'b0;
      r_winner    <= 2'b00;
      r_move_err  <= 1'b0;
      r_win_cells <= '0;
    end else begin
      r_move_err <= 1'b0;
      unique case (r_state)
        StPlay: begin
          if (bus.place) begin
            if (w_sel_free) begin
              for (int k = 0; k < 9; k++) begin
                if (bus.cell_sel == 4'(k)) r_grid[17-2*k -: 2] <= w_code;
              end
              r_state <= StCheck;
            end else begin
              r_move_err <= 1'b1;
            end
          end
        end
        StCheck: begin
          if (w_win_mask != '0) begin
            if (r_turn) r_p2_score <= bump(r_p2_score);
            else        r_p1_score <= bump(r_p1_score);
            r_winner    <= w_code;
            r_win_cells <= w_win_mask;
            r_state     <= StOver;
          end else if (&w_full) begin
            r_tie_score <= bump(r_tie_score);
            r_winner    <= 2'b11;
            r_state     <= StOver;
          end else begin
            r_turn  <= ~r_turn;
            r_state <= StPlay;
          end
        end
        StOver: begin
          if (bus.new_round) begin
            r_grid      <= '0;
            r_winner    <= 2'b00;
            r_win_cells <= '0;
            r_start     <= ~r_start;
            r_turn      <= ~r_start;
            r_state     <= StPlay;
          end
        end
        default: r_state <= StPlay;
      endcase
    end
  end

  assign bus.grid       = r_grid;
  assign bus.p1_score   = r_p1_score;
  assign bus.p2_score   = r_p2_score;
  assign bus.tie_score  = r_tie_score;
  assign bus.turn       = r_turn;
  assign bus.round_over = (r_state == StOver);
  assign bus.winner     = r_winner;
  assign bus.move_err   = r_move_err;
`ifdef GAME_CONTROLLER_WIN_LINE_EN
  assign bus.win_cells  = r_win_cells;
`else
  logic w_unused;
  assign w_unused = ^r_win_cells;
`endif

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: directed scenarios plus randomized rounds
// compared against a board-level reference model.
module tb_game_controller;

  logic clk;
  logic reset;
  game_controller_if bus ();

  game_controller #(.SCORE_MAX(4'd9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         board [9];
  int         m_turn, m_start, m_p1, m_p2, m_tie, m_winner;
  bit         m_over;
  logic [8:0] m_mask;
  int ln [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                    '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] pack_grid();
    logic [17:0] g;
    g = '0;
    for (int k = 0; k < 9; k++) g[17-2*k -: 2] = 2'(board[k]);
    return g;
  endfunction

  function automatic logic [8:0] lines_of(input int code);
    logic [8:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (board[ln[i][0]] == code && board[ln[i][1]] == code && board[ln[i][2]] == code) begin
        m[ln[i][0]] = 1'b1;
        m[ln[i][1]] = 1'b1;
        m[ln[i][2]] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic int wrap_inc(input int v);
    return (v == 9) ? 0 : v + 1;
  endfunction

  function automatic bit board_full();
    for (int k = 0; k < 9; k++) if (board[k] == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 9; k++) board[k] = 0;
    m_turn = 0; m_start = 0; m_p1 = 0; m_p2 = 0; m_tie = 0; m_winner = 0;
    m_over = 1'b0; m_mask = '0;
  endtask

  task automatic check_all(input string tag, input bit exp_err);
    check_eq({tag, "_grid"},   32'(bus.grid),       32'(pack_grid()));
    check_eq({tag, "_turn"},   32'(bus.turn),       32'(m_turn));
    check_eq({tag, "_over"},   32'(bus.round_over), 32'(m_over));
    check_eq({tag, "_winner"}, 32'(bus.winner),     32'(m_winner));
    check_eq({tag, "_p1"},     32'(bus.p1_score),   32'(m_p1));
    check_eq({tag, "_p2"},     32'(bus.p2_score),   32'(m_p2));
    check_eq({tag, "_tie"},    32'(bus.tie_score),  32'(m_tie));
    check_eq({tag, "_err"},    32'(bus.move_err),   32'(exp_err));
`ifdef GAME_CONTROLLER_WIN_LINE_EN
    check_eq({tag, "_wcells"}, 32'(bus.win_cells),  32'(m_mask));
`endif
  endtask

  task automatic do_place(input int c);
    logic [8:0] mask;
    @(negedge clk);
    bus.cell_sel = 4'(c);
    bus.place    = 1'b1;
    @(negedge clk);
    bus.place    = 1'b0;
    if (!m_over && c <= 8 && board[c] == 0) begin
      board[c] = m_turn + 1;
      check_all("place_acc", 1'b0);
      @(negedge clk);
      mask = lines_of(m_turn + 1);
      if (mask != '0) begin
        if (m_turn == 0) m_p1 = wrap_inc(m_p1);
        else             m_p2 = wrap_inc(m_p2);
        m_winner = m_turn + 1;
        m_mask   = mask;
        m_over   = 1'b1;
      end else if (board_full()) begin
        m_tie    = wrap_inc(m_tie);
        m_winner = 3;
        m_over   = 1'b1;
      end else begin
        m_turn = 1 - m_turn;
      end
      check_all("place_res", 1'b0);
    end else if (!m_over) begin
      check_all("place_rej", 1'b1);
      @(negedge clk);
      check_all("place_rej_end", 1'b0);
    end else begin
      check_all("place_over", 1'b0);
    end
  endtask

  task automatic do_new_round();
    @(negedge clk);
    bus.new_round = 1'b1;
    @(negedge clk);
    bus.new_round = 1'b0;
    if (m_over) begin
      for (int k = 0; k < 9; k++) board[k] = 0;
      m_start  = 1 - m_start;
      m_turn   = m_start;
      m_over   = 1'b0;
      m_winner = 0;
      m_mask   = '0;
    end
    check_all("new_round", 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("reset", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    check_all("reset_rel", 1'b0);
  endtask

  task automatic reset_in_check();
    @(negedge clk);
    bus.cell_sel = 4'd4;
    bus.place    = 1'b1;
    @(negedge clk);
    bus.place    = 1'b0;
    reset        = 1'b1;
    #1;
    model_reset();
    check_all("rst_check", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all("rst_check_after", 1'b0);
  endtask

  int seq_a [6] = '{0, 3, 1, 4, 8, 5};
  int seq_b [5] = '{3, 0, 4, 1, 5};
  int tie_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  initial begin
    int empties [$];
    int steps;
    reset         = 1'b1;
    bus.cell_sel  = '0;
    bus.place     = 1'b0;
    bus.new_round = 1'b0;
    model_reset();
    #1;
    check_all("por", 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // P1 wins on the top row
    do_place(0); do_place(3); do_place(1); do_place(4); do_place(2);
    check_eq("row_win_grid", 32'(bus.grid), 32'(18'b010101_101000_000000));
    check_eq("row_win_winner", 32'(bus.winner), 32'd1);
    do_place(5);
    do_new_round();
    check_eq("start_flip", 32'(bus.turn), 32'd1);

    // Rejected moves, then a full board with no line
    do_place(tie_seq[0]);
    do_place(tie_seq[0]);
    do_place(12);
    for (int i = 1; i < 9; i++) do_place(tie_seq[i]);
    check_eq("tie_winner", 32'(bus.winner), 32'd3);
    do_new_round();

    // Ten P2 wins drive p2_score through its wrap
    do_reset();
    for (int r = 0; r < 10; r++) begin
      if (m_start == 0) for (int i = 0; i < 6; i++) do_place(seq_a[i]);
      else              for (int i = 0; i < 5; i++) do_place(seq_b[i]);
      if (r == 9) check_eq("p2_wrap", 32'(bus.p2_score), 32'd0);
      do_new_round();
    end
    check_eq("p1_unaffected", 32'(bus.p1_score), 32'd0);

    reset_in_check();

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      steps = 0;
      while (!m_over && steps < 60) begin
        int roll;
        steps++;
        roll = int'($urandom_range(0, 99));
        if (roll < 8) begin
          do_place(int'($urandom_range(9, 15)));
        end else if (roll < 16) begin
          do_place(int'($urandom_range(0, 8)));
        end else if (roll < 22) begin
          do_new_round();
        end else if (roll < 23) begin
          do_reset();
        end else begin
          empties.delete();
          for (int k = 0; k < 9; k++) if (board[k] == 0) empties.push_back(k);
          do_place(empties[$urandom_range(0, empties.size() - 1)]);
        end
      end
      check_eq("round_done", 32'(m_over), 32'd1);
      if ($urandom_range(0, 1) == 1) do_place(int'($urandom_range(0, 15)));
      do_new_round();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have parameter SCORE_MAX, default 4'd9: the highest value any score counter holds before it wraps.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port cell_sel, input, 4 bits: target cell index, 0..8, row-major from top-left.
REQ-005 SHALL have port place, input, 1 bit: single-cycle request to place the current player's mark at cell_sel.
REQ-006 SHALL have port new_round, input, 1 bit: single-cycle request to start the next round.
REQ-007 SHALL have port grid, output, 18 bits: board state; cell k occupies grid[17-2k:16-2k]; 00 = empty, 01 = P1, 10 = P2; 11 is never driven.
REQ-008 SHALL have ports p1_score, p2_score and tie_score, output, 4 bits each: binary round tallies, each 0..SCORE_MAX.
REQ-009 SHALL have port turn, output, 1 bit: player to move; 0 = P1, 1 = P2.
REQ-010 SHALL have port round_over, output, 1 bit: high while state is OVER.
REQ-011 SHALL have port winner, output, 2 bits: 01 = P1, 10 = P2, 11 = tie, 00 = none; valid while round_over is high, otherwise 00.
REQ-012 SHALL have port move_err, output, 1 bit: one-cycle pulse on each rejected place.

Function
REQ-013 SHALL implement a three-state FSM with states PLAY, CHECK and OVER.
REQ-014 PLAY, accepted move: when place=1, cell_sel<=8 and that cell is 00, the cell SHALL take the current player's code at the next edge and the FSM SHALL go to CHECK.
REQ-015 PLAY, rejected move: when place=1 and either cell_sel>8 or the cell is non-empty, move_err SHALL be 1 for exactly the next cycle and grid, turn and state SHALL stay unchanged.
REQ-016 CHECK SHALL evaluate all 8 lines (3 rows, 3 columns, 2 diagonals) on the registered grid and take exactly one cycle.
REQ-017 CHECK, win: if any line holds three equal non-empty codes, that player's score SHALL increment, winner SHALL be set and the FSM SHALL go to OVER.
REQ-018 CHECK, tie: if there is no win and all 9 cells are non-empty, tie_score SHALL increment, winner SHALL be 11 and the FSM SHALL go to OVER.
REQ-019 CHECK, neither: turn SHALL toggle and the FSM SHALL return to PLAY.
REQ-020 Latency: for place accepted at edge N, grid SHALL update at N+1, and round_over or the turn toggle SHALL appear at N+2.
REQ-021 A win SHALL take priority over a full board (a win on the 9th move counts as a win, not a tie).
REQ-022 A score counter at SCORE_MAX that is incremented SHALL wrap to 0; no other counter SHALL be affected.
REQ-023 place SHALL be ignored in CHECK and OVER, with no move_err pulse.
REQ-024 new_round SHALL be ignored in PLAY and CHECK.
REQ-025 OVER: on new_round the grid SHALL clear to all 00, winner SHALL clear to 00, the FSM SHALL go to PLAY, and turn SHALL become the inverse of the previous round's starting player.
REQ-026 If place and new_round are asserted together, only the input relevant to the current state SHALL act, per REQ-023 and REQ-024.

Reset
REQ-027 While reset=1, asynchronously: grid=0, all scores=0, turn=0, starting player=P1, state=PLAY, round_over=0, winner=00, move_err=0.
REQ-028 Reset asserted mid-round or mid-CHECK SHALL discard the round in progress; no score SHALL change.

Configuration
REQ-029 With GAME_CONTROLLER_WIN_LINE_EN defined, the block SHALL add output win_cells[8:0], a mask of the cells on the winning line(s), bit k = cell k.
REQ-030 win_cells SHALL be valid in OVER after a win, 0 otherwise, and cleared by reset and new_round.
REQ-031 Without GAME_CONTROLLER_WIN_LINE_EN, the port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 P1 plays cells 0, 1, 2 and P2 plays 3, 4, in alternation -> after the 5th accepted place, round_over=1 two cycles later, winner=01, p1_score=1, grid=18'b010101_101000_000000, win_cells=9'b000000111.
REQ-033 Full board with no line, e.g. 0,1,2,4,3,5,7,6,8 -> winner=11, tie_score=1, other scores unchanged.
REQ-034 place on an occupied cell, then place with cell_sel=4'd12 -> two single-cycle move_err pulses; grid and turn unchanged.
REQ-035 p2_score=9 and P2 wins -> p2_score=0; then new_round -> grid=0, turn flips relative to the previous start.
REQ-036 reset pulsed one cycle after an accepted place (during CHECK) -> all outputs at reset values immediately and no score change; place during OVER -> ignored, no move_err.
